// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, sequencer states and default width for the 4-bit ALU
package alu_pkg;

   localparam int WIDTH_DEF = 4;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_NOT  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;
   localparam logic [2:0] ALU_OR   = 3'b100;
   localparam logic [2:0] ALU_XOR  = 3'b101;
   localparam logic [2:0] ALU_LESS = 3'b110;
   localparam logic [2:0] ALU_EQ   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/alu_cmd_seq_if.sv
// rtl/alu_cmd_seq_if.sv - command, ALU-side and response signals of the ALU command sequencer
interface alu_cmd_seq_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic             cmd_acc;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_ctr;
   logic [WIDTH-1:0] alu_out;
   logic             alu_of;
   logic             alu_zf;
   logic             alu_cf;
   logic             alu_less;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_of;
   logic             rsp_zf;
   logic             rsp_cf;
   logic             rsp_less;

   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] op_cnt;

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc,
      input  alu_out, alu_of, alu_zf, alu_cf, alu_less,
      input  rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_ctr,
      output rsp_valid, rsp_result, rsp_of, rsp_zf, rsp_cf, rsp_less,
      output acc, op_cnt
   );

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc,
      output alu_out, alu_of, alu_zf, alu_cf, alu_less,
      output rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_ctr,
      input  rsp_valid, rsp_result, rsp_of, rsp_zf, rsp_cf, rsp_less,
      input  acc, op_cnt
   );
endinterface

// File: rtl/alu_cmd_seq.sv
// rtl/alu_cmd_seq.sv - IDLE/EXEC/HOLD sequencer feeding the combinational ALU and returning its result
// Optional sticky overflow flag: ALU_CMD_SEQ_STICKY_OF_EN
module alu_cmd_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic rst,
`ifdef ALU_CMD_SEQ_STICKY_OF_EN
   input  logic sticky_clr,
   output logic sticky_of,
`endif
   alu_cmd_seq_if.slave bus
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_EXEC = EXEC;
   localparam logic [1:0] S_HOLD = HOLD;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_ctr_q, alu_ctr_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
   logic             cmd_ready;
   logic             take;

   assign cmd_ready = (state_q == S_IDLE) || (state_q == S_HOLD && bus.rsp_ready);
   assign take      = bus.cmd_valid && cmd_ready;

   always_comb begin
      state_d     = state_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_ctr_d   = alu_ctr_q;
      result_d    = result_q;
      flags_d     = flags_q;
      rsp_valid_d = rsp_valid_q;
      acc_d       = acc_q;
      op_cnt_d    = op_cnt_q;
      case (state_q)
         S_EXEC: begin
            result_d    = bus.alu_out;
            acc_d       = bus.alu_out;
            flags_d     = {bus.alu_of, bus.alu_zf, bus.alu_cf, bus.alu_less};
            rsp_valid_d = 1'b1;
            state_d     = S_HOLD;
         end
         S_HOLD: begin
            if (bus.rsp_ready) begin
               op_cnt_d    = op_cnt_q + CNT_W'(1);
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         S_IDLE: ;
         default: state_d = S_IDLE;
      endcase
      // acc_q already holds the result captured in the previous EXEC
      if (take) begin
         alu_a_d   = bus.cmd_acc ? acc_q : bus.cmd_a;
         alu_b_d   = bus.cmd_b;
         alu_ctr_d = bus.cmd_op;
         state_d   = S_EXEC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ctr_q   <= '0;
         result_q    <= '0;
         flags_q     <= '0;
         rsp_valid_q <= 1'b0;
         acc_q       <= '0;
         op_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_ctr_q   <= alu_ctr_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         rsp_valid_q <= rsp_valid_d;
         acc_q       <= acc_d;
         op_cnt_q    <= op_cnt_d;
      end
   end

`ifdef ALU_CMD_SEQ_STICKY_OF_EN
   logic sticky_q, sticky_d;

   always_comb begin
      sticky_d = sticky_q;
      if (sticky_clr)
         sticky_d = 1'b0;
      if (state_q == S_EXEC && bus.alu_of)
         sticky_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sticky_q <= 1'b0;
      else
         sticky_q <= sticky_d;
   end

   assign sticky_of = sticky_q;
`endif

   assign bus.cmd_ready  = cmd_ready;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_ctr    = alu_ctr_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = result_q;
   assign bus.rsp_of     = flags_q[3];
   assign bus.rsp_zf     = flags_q[2];
   assign bus.rsp_cf     = flags_q[1];
   assign bus.rsp_less   = flags_q[0];
   assign bus.acc        = acc_q;
   assign bus.op_cnt     = op_cnt_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb/tb_alu_cmd_seq.sv - directed bench for alu_cmd_seq with a behavioural 4-bit ALU beside it
module tb_alu_cmd_seq;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

`ifdef ALU_CMD_SEQ_STICKY_OF_EN
   logic sticky_clr = 1'b0;
   logic sticky_of;
`endif

   alu_cmd_seq_if #(.WIDTH(4), .CNT_W(8)) bus ();

   alu_cmd_seq #(.WIDTH(4), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef ALU_CMD_SEQ_STICKY_OF_EN
      .sticky_clr (sticky_clr),
      .sticky_of  (sticky_of),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // Reference ALU: compare ops derive from a - b; less flag is the unsigned borrow
   logic [4:0] sum5, dif5;
   logic       add_of, sub_of;
   logic [3:0] a_m, b_m, out_m;
   always_comb begin
      a_m    = bus.alu_a;
      b_m    = bus.alu_b;
      sum5   = {1'b0, a_m} + {1'b0, b_m};
      dif5   = {1'b0, a_m} + {1'b0, ~b_m} + 5'd1;
      add_of = (a_m[3] == b_m[3]) && (sum5[3] != a_m[3]);
      sub_of = (a_m[3] != b_m[3]) && (dif5[3] != a_m[3]);
      out_m  = 4'd0;
      bus.alu_of   = 1'b0;
      bus.alu_cf   = 1'b0;
      bus.alu_less = 1'b0;
      case (bus.alu_ctr)
         ALU_ADD: begin out_m = sum5[3:0]; bus.alu_of = add_of; bus.alu_cf = sum5[4]; end
         ALU_SUB, ALU_LESS, ALU_EQ: begin
            bus.alu_of   = sub_of;
            bus.alu_cf   = dif5[4];
            bus.alu_less = ~dif5[4];
            if (bus.alu_ctr == ALU_SUB)       out_m = dif5[3:0];
            else if (bus.alu_ctr == ALU_LESS) out_m = {3'b000, sub_of ^ dif5[3]};
            else                              out_m = {3'b000, dif5[3:0] == 4'd0};
         end
         ALU_NOT: out_m = ~a_m;
         ALU_AND: out_m = a_m & b_m;
         ALU_OR:  out_m = a_m | b_m;
         default: out_m = a_m ^ b_m;
      endcase
      bus.alu_out = out_m;
      bus.alu_zf  = (bus.alu_ctr inside {ALU_SUB, ALU_LESS, ALU_EQ}) ? (dif5[3:0] == 4'd0)
                                                                    : (out_m == 4'd0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Presents a command and returns once it has been accepted (bounded wait)
   task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic accsel);
      int n;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_acc   = accsel;
      n = 0;
      while (!bus.cmd_ready && n < 20) begin
         tick();
         n++;
      end
      chk("send_ready_timeout", 32'(bus.cmd_ready), 32'd1);
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic run(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic accsel);
      send(op, a, b, accsel);
      tick();
      chk("run_rsp_valid", 32'(bus.rsp_valid), 32'd1);
   endtask

   task automatic consume;
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd0;
      bus.cmd_a     = 4'd0;
      bus.cmd_b     = 4'd0;
      bus.cmd_acc   = 1'b0;
      bus.rsp_ready = 1'b0;
      tick();
      tick();
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
      chk("rst_alu_ctr", 32'(bus.alu_ctr), 32'd0);
      chk("rst_acc", 32'(bus.acc), 32'd0);
      chk("rst_op_cnt", 32'(bus.op_cnt), 32'd0);
      rst = 1'b0;
      tick();

      // add 3+4: EXEC after acceptance edge, response after the next edge
      send(ALU_ADD, 4'h3, 4'h4, 1'b0);
      chk("add_exec_valid", 32'(bus.rsp_valid), 32'd0);
      chk("add_alu_a", 32'(bus.alu_a), 32'h3);
      chk("add_alu_b", 32'(bus.alu_b), 32'h4);
      chk("add_exec_ready", 32'(bus.cmd_ready), 32'd0);
      tick();
      chk("add_valid", 32'(bus.rsp_valid), 32'd1);
      chk("add_result", 32'(bus.rsp_result), 32'h7);
      chk("add_flags", 32'({bus.rsp_of, bus.rsp_zf, bus.rsp_cf, bus.rsp_less}), 32'b0000);
      chk("add_acc", 32'(bus.acc), 32'h7);
      consume();
      chk("add_op_cnt", 32'(bus.op_cnt), 32'd1);
      chk("add_valid_clr", 32'(bus.rsp_valid), 32'd0);

      run(ALU_ADD, 4'h7, 4'h1, 1'b0);
      chk("ovf_result", 32'(bus.rsp_result), 32'h8);
      chk("ovf_of", 32'(bus.rsp_of), 32'd1);
`ifdef ALU_CMD_SEQ_STICKY_OF_EN
      chk("sticky_set", 32'(sticky_of), 32'd1);
`endif
      consume();

      run(ALU_SUB, 4'h0, 4'h1, 1'b0);
      chk("sub_result", 32'(bus.rsp_result), 32'hF);
      chk("sub_cf", 32'(bus.rsp_cf), 32'd0);
      chk("sub_of", 32'(bus.rsp_of), 32'd0);
`ifdef ALU_CMD_SEQ_STICKY_OF_EN
      chk("sticky_hold", 32'(sticky_of), 32'd1);
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      chk("sticky_clr", 32'(sticky_of), 32'd0);
`endif
      consume();

      run(ALU_EQ, 4'h5, 4'h5, 1'b0);
      chk("eq_result", 32'(bus.rsp_result), 32'h1);
      chk("eq_zf", 32'(bus.rsp_zf), 32'd1);
      chk("eq_cf", 32'(bus.rsp_cf), 32'd1);
      consume();

      run(ALU_LESS, 4'hE, 4'h1, 1'b0);
      chk("less_result", 32'(bus.rsp_result), 32'h1);
      chk("less_flag", 32'(bus.rsp_less), 32'd0);
      consume();
      chk("op_cnt_5", 32'(bus.op_cnt), 32'd5);

      // backpressure: pending command must wait while the response is held
      run(ALU_ADD, 4'h1, 4'h1, 1'b0);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = ALU_XOR;
      bus.cmd_a     = 4'h6;
      bus.cmd_b     = 4'h3;
      bus.cmd_acc   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         chk("bp_result", 32'(bus.rsp_result), 32'h2);
         chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_op_cnt", 32'(bus.op_cnt), 32'd5);
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.cmd_ready), 32'd1);
      tick();
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b0;
      chk("bp_op_cnt_inc", 32'(bus.op_cnt), 32'd6);
      chk("bp_b2b_valid", 32'(bus.rsp_valid), 32'd0);
      chk("bp_b2b_ctr", 32'(bus.alu_ctr), 32'(ALU_XOR));
      chk("bp_b2b_a", 32'(bus.alu_a), 32'h6);
      tick();
      chk("bp_xor_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_xor_result", 32'(bus.rsp_result), 32'h5);
      consume();

      // accumulate chain: cmd_a is ignored when cmd_acc is set
      run(ALU_ADD, 4'h2, 4'h1, 1'b0);
      chk("acc1_result", 32'(bus.rsp_result), 32'h3);
      consume();
      run(ALU_ADD, 4'hF, 4'h3, 1'b1);
      chk("acc2_alu_a", 32'(bus.alu_a), 32'h3);
      chk("acc2_result", 32'(bus.rsp_result), 32'h6);
      chk("acc2_acc", 32'(bus.acc), 32'h6);
      consume();
      chk("op_cnt_9", 32'(bus.op_cnt), 32'd9);

      // reset while in EXEC drops the command
      send(ALU_ADD, 4'h1, 4'h1, 1'b0);
      rst = 1'b1;
      #2;
      chk("rexec_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rexec_idle", 32'(bus.cmd_ready), 32'd1);
      chk("rexec_acc", 32'(bus.acc), 32'd0);
      chk("rexec_op_cnt", 32'(bus.op_cnt), 32'd0);
      chk("rexec_alu_a", 32'(bus.alu_a), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rexec_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
